hc595_drive: RTL and testbench

- Serial-in/parallel-out driver for a chain of SN74HC595 shift/latch registers. It is the output-side counterpart of the HC165 parallel-load reader.
- Accepts a DATA_WIDTH-bit word on a start strobe, shifts it out on SER/SRCLK, then pulses RCLK so the new word appears on the 595 outputs in one update.
- Sits between the acquisition/sequencer FSM and the board-level source/mux enable lines (e.g. 4 chained chips = 32 select lines).

---
 rtl/hc595_drive.sv | 139 +++++++++++++
 tb/tb_hc595_drive.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hc595_drive.sv
// rtl/hc595_drive.sv - SN74HC595 chain serial driver; optional macro HC595_OE_BLANK_EN blanks OE_n during each update
module hc595_drive #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 5,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ser,
  output logic                  o_shift_clk,
  output logic                  o_latch_clk,
  output logic                  o_oe_n,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CW    = $clog2(DATA_WIDTH + 1);
  localparam int DVW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FIRST = MSB_FIRST ? DATA_WIDTH - 1 : 0;
  localparam logic [CW-1:0]  BITS_LAST = CW'(DATA_WIDTH);
  localparam logic [DVW-1:0] DIV_LAST  = DVW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LOW,
    SHIFT_HIGH,
    LATCH_LOW,
    LATCH_HIGH
  } state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] sreg, sreg_n, sreg_shift;
  logic [CW-1:0]         bit_cnt, bit_cnt_n, bit_inc;
  logic [DVW-1:0]        div_cnt, div_cnt_n;
  logic                  ser_n, sck_n, rck_n, oe_n_n, busy_n, done_n;
  logic                  tick, accept;

  // Each FSM state lasts exactly one divider period; tick marks its last cycle.
  assign tick       = (div_cnt == DIV_LAST);
  // A start on the o_done cycle is dropped so the earliest accept is the cycle after.
  assign accept     = (state == IDLE) && i_start && !o_done;
  assign bit_inc    = bit_cnt + 1'b1;
  // The next bit to present always moves into the FIRST position.
  assign sreg_shift = MSB_FIRST ? (sreg << 1) : (sreg >> 1);

  // Next-state and next-output computation; all outputs are registered.
  always_comb begin
    state_n   = state;
    sreg_n    = sreg;
    bit_cnt_n = bit_cnt;
    div_cnt_n = (state == IDLE || tick) ? '0 : div_cnt + 1'b1;
    ser_n     = o_ser;
    sck_n     = o_shift_clk;
    rck_n     = o_latch_clk;
    oe_n_n    = o_oe_n;
    busy_n    = o_busy;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          sreg_n    = i_data;
          ser_n     = i_data[FIRST];
          busy_n    = 1'b1;
          bit_cnt_n = '0;
          div_cnt_n = '0;
`ifdef HC595_OE_BLANK_EN
          oe_n_n    = 1'b1;
`endif
          state_n   = SHIFT_LOW;
        end
      end
      SHIFT_LOW: begin
        if (tick) begin
          sck_n   = 1'b1;
          state_n = SHIFT_HIGH;
        end
      end
      SHIFT_HIGH: begin
        if (tick) begin
          sck_n     = 1'b0;
          bit_cnt_n = bit_inc;
          if (bit_inc == BITS_LAST) begin
            state_n = LATCH_LOW;
          end else begin
            sreg_n  = sreg_shift;
            ser_n   = sreg_shift[FIRST];
            state_n = SHIFT_LOW;
          end
        end
      end
      LATCH_LOW: begin
        if (tick) begin
          rck_n   = 1'b1;
          state_n = LATCH_HIGH;
        end
      end
      LATCH_HIGH: begin
        if (tick) begin
          rck_n   = 1'b0;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          oe_n_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and output registers with synchronous abort on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sreg        <= '0;
      bit_cnt     <= '0;
      div_cnt     <= '0;
      o_ser       <= 1'b0;
      o_shift_clk <= 1'b0;
      o_latch_clk <= 1'b0;
      o_oe_n      <= 1'b1;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state       <= state_n;
      sreg        <= sreg_n;
      bit_cnt     <= bit_cnt_n;
      div_cnt     <= div_cnt_n;
      o_ser       <= ser_n;
      o_shift_clk <= sck_n;
      o_latch_clk <= rck_n;
      o_oe_n      <= oe_n_n;
      o_busy      <= busy_n;
      o_done      <= done_n;
    end
  end

endmodule

// File: tb/tb_hc595_drive.sv
// tb/tb_hc595_drive.sv - directed table-driven bench for hc595_drive (8-bit MSB-first and 32-bit LSB-first chains)
module tb_hc595_drive;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       i_start = 1'b0;
  logic [7:0] i_data  = 8'h00;
  logic       ser, sck, rck, oe_n, busy, done;

  logic        s32 = 1'b0;
  logic [31:0] d32 = 32'h0;
  logic        ser32, sck32, rck32, oe32, busy32, done32;

  hc595_drive u_dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_data(i_data),
    .o_ser(ser), .o_shift_clk(sck), .o_latch_clk(rck),
    .o_oe_n(oe_n), .o_busy(busy), .o_done(done)
  );

  hc595_drive #(.DATA_WIDTH(32), .CLK_DIV(2), .MSB_FIRST(1'b0)) u_dut32 (
    .clk(clk), .rst(rst), .i_start(s32), .i_data(d32),
    .o_ser(ser32), .o_shift_clk(sck32), .o_latch_clk(rck32),
    .o_oe_n(oe32), .o_busy(busy32), .o_done(done32)
  );

`ifdef HC595_OE_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  int          sck_rises = 0, rck_rises = 0, done_cnt = 0, overlap = 0;
  int          sck32_rises = 0, rck32_rises = 0, overlap32 = 0;
  logic        sck_q = 1'b0, rck_q = 1'b0, sck32_q = 1'b0, rck32_q = 1'b0;
  logic [7:0]  rx8  = 8'h00;
  logic [31:0] rx32 = 32'h0;

  // Free-running cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Pin monitor: models the 595 chain by sampling SER on each SRCLK rise.
  always @(negedge clk) begin
    sck_q   <= sck;
    rck_q   <= rck;
    sck32_q <= sck32;
    rck32_q <= rck32;
    if (sck && !sck_q) begin
      sck_rises <= sck_rises + 1;
      rx8       <= {rx8[6:0], ser};
    end
    if (rck && !rck_q) rck_rises <= rck_rises + 1;
    if (rck && sck) overlap <= overlap + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (sck32 && !sck32_q) begin
      sck32_rises <= sck32_rises + 1;
      rx32        <= {ser32, rx32[31:1]};
    end
    if (rck32 && !rck32_q) rck32_rises <= rck32_rises + 1;
    if (rck32 && sck32) overlap32 <= overlap32 + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  int t0, lim, b_sck, b_rck, b_done;

  task automatic start8(input logic [7:0] d);
    @(negedge clk);
    i_data  = d;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done8();
    lim = cyc + 3000;
    while (!done && cyc < lim) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic snap();
    b_sck  = sck_rises;
    b_rck  = rck_rises;
    b_done = done_cnt;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk1({tag, "_ser"},  ser,  1'b0);
    chk1({tag, "_sck"},  sck,  1'b0);
    chk1({tag, "_rck"},  rck,  1'b0);
    chk1({tag, "_oe_n"}, oe_n, 1'b1);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_word;
    logic       exp_first;
    logic       exp_oe_mid;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 1'b1, 1'b1};
    vecs[1] = '{8'hFF, 8'hFF, 1'b1, BLANK};
    vecs[2] = '{8'h00, 8'h00, 1'b0, BLANK};
    vecs[3] = '{8'h3C, 8'h3C, 1'b0, BLANK};
    vecs[4] = '{8'h01, 8'h01, 1'b0, BLANK};
    vecs[5] = '{8'h80, 8'h80, 1'b1, BLANK};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    chk1("reset_oe32", oe32, 1'b1);
    chk1("reset_busy32", busy32, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      snap();
      start8(vecs[i].data);
      chk1("vec_first_ser", ser, vecs[i].exp_first);
      chk1("vec_busy_on_accept", busy, 1'b1);
      chk1("vec_oe_mid", oe_n, vecs[i].exp_oe_mid);
      wait_done8();
      chk("vec_latency", cyc - t0, 90);
      chk1("vec_busy_at_done", busy, 1'b0);
      chk1("vec_oe_after", oe_n, 1'b0);
      @(negedge clk); #1;
      chk("vec_sck_edges", sck_rises - b_sck, 8);
      chk("vec_rck_edges", rck_rises - b_rck, 1);
      chk("vec_done_pulses", done_cnt - b_done, 1);
      chk("vec_word", 32'(rx8), 32'(vecs[i].exp_word));
    end

    // Start while busy and data change after accept must not disturb the transfer.
    snap();
    start8(8'h5A);
    repeat (19) @(posedge clk);
    @(negedge clk);
    i_start = 1'b1;
    i_data  = 8'hC3;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_data  = 8'hE7;
    wait_done8();
    chk("ign_latency", cyc - t0, 90);
    @(negedge clk); #1;
    chk("ign_word", 32'(rx8), 32'h5A);
    chk("ign_done_pulses", done_cnt - b_done, 1);
    chk("ign_sck_edges", sck_rises - b_sck, 8);
    repeat (3) @(posedge clk);
    #1;
    chk1("ign_idle_after", busy, 1'b0);

    // Back-to-back with i_start held: one idle cycle after each o_done.
    @(negedge clk);
    i_data  = 8'h11;
    i_start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    i_data = 8'h22;
    wait_done8();
    chk("b2b_latency1", cyc - t0, 90);
    @(negedge clk); #1;
    chk("b2b_word1", 32'(rx8), 32'h11);
    @(posedge clk); #1;
    chk1("b2b_idle_busy", busy, 1'b0);
    chk1("b2b_idle_oe", oe_n, 1'b0);
    @(posedge clk); #1;
    chk1("b2b_reaccept_busy", busy, 1'b1);
    chk1("b2b_oe_mid2", oe_n, BLANK);
    t0 = cyc;
    i_data = 8'h33;
    wait_done8();
    i_start = 1'b0;
    chk("b2b_latency2", cyc - t0, 90);
    chk1("b2b_oe_after2", oe_n, 1'b0);
    @(negedge clk); #1;
    chk("b2b_word2", 32'(rx8), 32'h22);
    repeat (3) @(posedge clk);
    #1;
    chk1("b2b_stopped", busy, 1'b0);

    // Reset mid-shift aborts with no latch pulse; a later transfer completes.
    start8(8'h96);
    repeat (39) @(posedge clk);
    @(negedge clk);
    snap();
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outs("midrst");
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    chk("midrst_no_rck", rck_rises - b_rck, 0);
    rst = 1'b0;
    snap();
    start8(8'h69);
    chk1("post_rst_busy", busy, 1'b1);
    chk1("post_rst_oe", oe_n, 1'b1);
    wait_done8();
    chk("post_rst_latency", cyc - t0, 90);
    @(negedge clk); #1;
    chk("post_rst_word", 32'(rx8), 32'h69);
    chk("post_rst_rck", rck_rises - b_rck, 1);

    // 32-bit LSB-first chain with a single set bit.
    b_sck = sck32_rises;
    b_rck = rck32_rises;
    @(negedge clk);
    d32 = 32'h0000_0001;
    s32 = 1'b1;
    @(posedge clk); #1;
    s32 = 1'b0;
    t0  = cyc;
    chk1("w32_first_ser", ser32, 1'b1);
    lim = cyc + 3000;
    while (!done32 && cyc < lim) begin
      @(posedge clk); #1;
    end
    chk("w32_latency", cyc - t0, 132);
    chk1("w32_oe_after", oe32, 1'b0);
    @(negedge clk); #1;
    chk("w32_sck_edges", sck32_rises - b_sck, 32);
    chk("w32_rck_edges", rck32_rises - b_rck, 1);
    chk("w32_word", rx32, 32'h0000_0001);

    chk("overlap8", overlap, 0);
    chk("overlap32", overlap32, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
